fetch_queue: RTL and testbench

Instruction-fetch front end for the 5-stage pipelined CPU. It owns the program counter and drives the combinational instruction memory. It buffers fetched {pc+4, instr} pairs in a small FIFO and presents them to the IF/ID pipe register with a valid/ready handshake. Stall comes from the hazard logic via ready_i; redirect comes from branch resolution and flushes the queue.

---
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner and first-word-fall-through fetch queue feeding IF/ID.
// Optional stall/flush counters are built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [31:0]              imem_addr_o,
    input  logic [31:0]              imem_instr_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_plus4_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]              stall_cycles_o,
    output logic [31:0]              flushed_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [31:0]   pc4_mem_q   [DEPTH];
    logic [31:0]   pc4_mem_d   [DEPTH];

    logic pop;
    logic push;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, redirect_pc_i[1:0]};

    assign valid_o     = (count_q != '0);
    assign instr_o     = valid_o ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign pc_plus4_o  = valid_o ? pc4_mem_q[rd_ptr_q]   : 32'd0;
    assign count_o     = count_q;
    assign imem_addr_o = pc_q;

    // A pop frees a slot in the same cycle, so a full queue still pushes when it pops.
    assign pop  = valid_o && ready_i && !redirect_i;
    assign push = !redirect_i && ((count_q != CW'(DEPTH)) || pop);

    always_comb begin
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc4_mem_d   = pc4_mem_q;
        if (redirect_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = imem_instr_i;
                pc4_mem_d[wr_ptr_q]   = pc_q + 32'd4;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        instr_mem_q <= instr_mem_d;
        pc4_mem_q   <= pc4_mem_d;
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flushed_q, flushed_d;
    logic [32:0] flushed_sum;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flushed_d      = flushed_q;
        flushed_sum    = {1'b0, flushed_q} + 33'(count_q);
        if (valid_o && !ready_i && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (redirect_i) begin
            flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flushed_q      <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flushed_q      <= flushed_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flushed_o      = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (DEPTH=4, RESET_PC=0).
module tb_fetch_queue;

    logic        clk;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic [2:0]  count_o;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flushed_o;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_plus4_o    (pc_plus4_o),
        .count_o       (count_o)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flushed_o     (flushed_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected stream from a fetch target onwards, replacing anything still pending.
    task automatic start_stream(input logic [31:0] addr);
        logic [31:0] a;
        exp_t        e;
        exp_q.delete();
        a = addr;
        for (int i = 0; i < 64; i++) begin
            e.instr = mem_word(a);
            e.pc4   = a + 32'd4;
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && !redirect_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pop_instr", instr_o, e.instr);
                check("pop_pc4", pc_plus4_o, e.pc4);
            end
        end
    end

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        ready_i       = 1'b1;
        cyc();
        cyc();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_count", {29'd0, count_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc4", pc_plus4_o, 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);

        start_stream(32'd0);
        rst_i   = 1'b0;
        ready_i = 1'b0;
        check("first_valid_pre", {31'd0, valid_o}, 32'd0);
        cyc();
        check("first_valid", {31'd0, valid_o}, 32'd1);
        check("first_count", {29'd0, count_o}, 32'd1);
        for (int i = 0; i < 9; i++) cyc();
        check("stall_count", {29'd0, count_o}, 32'd4);
        check("stall_addr", imem_addr_o, 32'h10);
        check("stall_head", instr_o, 32'h1000_0000);
        check("stall_head_pc4", pc_plus4_o, 32'd4);

        ready_i = 1'b1;
        cyc();
        ready_i = 1'b0;
        check("full_pp_count", {29'd0, count_o}, 32'd4);
        check("full_pp_head", instr_o, 32'h1000_0001);
        check("full_pp_addr", imem_addr_o, 32'h14);

        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("stream_valid", {31'd0, valid_o}, 32'd1);
            check("stream_count", {29'd0, count_o}, 32'd4);
        end

        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        ready_i       = 1'b0;
        start_stream(32'h80);
        cyc();
        redirect_i = 1'b0;
        check("flush_count", {29'd0, count_o}, 32'd0);
        check("flush_instr", instr_o, 32'd0);
        cyc();
        cyc();
        cyc();
        check("three_count", {29'd0, count_o}, 32'd3);

        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        ready_i       = 1'b1;
        start_stream(32'h40);
        cyc();
        redirect_i = 1'b0;
        ready_i    = 1'b0;
        check("redir_valid", {31'd0, valid_o}, 32'd0);
        check("redir_count", {29'd0, count_o}, 32'd0);
        cyc();
        check("redir_valid2", {31'd0, valid_o}, 32'd1);
        check("redir_instr", instr_o, 32'h1000_0010);
        check("redir_pc4", pc_plus4_o, 32'h44);
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        redirect_i    = 1'b1;
        redirect_pc_i = 32'h47;
        start_stream(32'h44);
        cyc();
        redirect_i = 1'b0;
        check("misalign_addr", imem_addr_o, 32'h44);
        for (int i = 0; i < 6; i++) cyc();

        rst_i         = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        cyc();
        rst_i      = 1'b0;
        redirect_i = 1'b0;
        check("rst_prio_addr", imem_addr_o, 32'd0);
        check("rst_prio_count", {29'd0, count_o}, 32'd0);
        check("rst_prio_valid", {31'd0, valid_o}, 32'd0);
        start_stream(32'd0);
        for (int i = 0; i < 6; i++) cyc();

        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        ready_i       = 1'b0;
        start_stream(32'hFFFF_FFFC);
        cyc();
        redirect_i = 1'b0;
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc();
        check("wrap_pc4", pc_plus4_o, 32'd0);
        check("wrap_instr", instr_o, 32'h4FFF_FFFF);
        check("wrap_next_addr", imem_addr_o, 32'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
